// File: rtl/seq_loop_mon_pkg.sv
// Shared types and helpers for the sequential-loop status monitor.
//   txn_state_e  : top-level transaction FSM states
//   loop_state_e : loop tracker FSM states
//   sat_inc()    : saturating increment for counters of any width up to MAX_CNT_W
package seq_loop_mon_pkg;

  typedef enum logic {TXN_IDLE, TXN_BUSY} txn_state_e;
  typedef enum logic {LOOP_IDLE, LOOP_IN} loop_state_e;

  localparam int unsigned MAX_CNT_W = 64;

  // Increment value, holding at all-ones for a counter that is `width` bits wide.
  // Callers zero-extend into MAX_CNT_W and truncate the result back.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                   input int unsigned          width);
    logic [MAX_CNT_W-1:0] max_val;
    // For width == MAX_CNT_W the shift yields 0 and the subtraction wraps to all-ones.
    max_val = (MAX_CNT_W'(1) << width) - MAX_CNT_W'(1);
    return (value == max_val) ? value : value + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/seq_loop_tracker.sv
// Loop tracker: follows one sequential loop of the observed FSM and reports
// trip count and cycle count of the most recent completed loop execution.
// Ports:
//   clock, reset           : clock, async active-high reset
//   enable                 : 0 freezes the FSM and all counters
//   cur_state, prev_state  : observed FSM state this cycle / last cycle
//   *_state, *_valid       : loop boundary states and their qualifiers
//   one_state_loop         : body is one state; every iter_start cycle is an iteration
//   one_state_block        : entry needs no pre-state qualification
//   in_loop                : loop execution in progress
//   loop_exec_count        : completed loop executions
//   loop_last_trip         : iterations of the last execution
//   loop_last_cycles       : cycles of the last execution (post-state cycle excluded)
module seq_loop_tracker
  import seq_loop_mon_pkg::*;
#(
  parameter int STATE_W = 9,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] prev_state,
  input  logic [STATE_W-1:0] pre_loop_state,
  input  logic               pre_states_valid,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_end_states_valid,
  input  logic [STATE_W-1:0] quit_loop_state,
  input  logic               quit_states_valid,
  input  logic [STATE_W-1:0] post_loop_state,
  input  logic               post_states_valid,
  input  logic               one_state_loop,
  input  logic               one_state_block,
  output logic               in_loop,
  output logic [CNT_W-1:0]   loop_exec_count,
  output logic [CNT_W-1:0]   loop_last_trip,
  output logic [CNT_W-1:0]   loop_last_cycles
);

  loop_state_e      state_q, state_d;
  logic             entry_hit, iter_hit, exit_hit;
  logic             do_enter, do_exit;
  logic [CNT_W-1:0] cycle_q, trip_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d  = state_q;
    do_enter = 1'b0;
    do_exit  = 1'b0;

    entry_hit = (cur_state == iter_start_state) &&
                (one_state_block || (pre_states_valid && (prev_state == pre_loop_state)));
    iter_hit  = one_state_loop ? (cur_state == iter_start_state)
                               : (iter_end_states_valid && (cur_state == iter_end_state));
    exit_hit  = quit_states_valid && post_states_valid &&
                (prev_state == quit_loop_state) && (cur_state == post_loop_state);

    if (enable) begin
      case (state_q)
        LOOP_IDLE: if (entry_hit) begin
          state_d  = LOOP_IN;
          do_enter = 1'b1;
        end
        LOOP_IN: if (exit_hit) begin
          state_d = LOOP_IDLE;
          do_exit = 1'b1;
        end
        default: state_d = LOOP_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= LOOP_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_q          <= '0;
      trip_q           <= '0;
      loop_exec_count  <= '0;
      loop_last_trip   <= '0;
      loop_last_cycles <= '0;
    end else if (do_enter) begin
      cycle_q <= CNT_W'(1);
      // The entry cycle can itself close an iteration (single-state body).
      trip_q  <= iter_hit ? CNT_W'(1) : '0;
    end else if (do_exit) begin
      loop_last_trip   <= trip_q;
      loop_last_cycles <= cycle_q;
      loop_exec_count  <= CNT_W'(sat_inc(MAX_CNT_W'(loop_exec_count), CNT_W));
    end else if (enable && (state_q == LOOP_IN)) begin
      cycle_q <= CNT_W'(sat_inc(MAX_CNT_W'(cycle_q), CNT_W));
      if (iter_hit) trip_q <= CNT_W'(sat_inc(MAX_CNT_W'(trip_q), CNT_W));
    end
  end

  assign in_loop = (state_q == LOOP_IN);

endmodule

// File: rtl/seq_loop_status_monitor.sv
// Run-time status monitor for an HLS accelerator. Observes the ap_* handshake
// and the one-hot control FSM; reports transaction count/latency and, via
// seq_loop_tracker, trip and cycle counts of one sequential loop.
// Ports:
//   clock, reset                  : clock, async active-high reset
//   ap_start/ready/done/continue  : observed block-level handshake
//   finish                        : first assertion freezes every counter (sticky)
//   cur_state                     : observed ap_CS_fsm
//   loop boundary states/valids   : see seq_loop_tracker
//   busy, in_loop, frozen         : status flags
//   txn_count, txn_last_lat       : completed transactions / cycles of the last one
//   loop_exec_count, loop_last_*  : loop statistics
module seq_loop_status_monitor
  import seq_loop_mon_pkg::*;
#(
  parameter int STATE_W = 9,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic               finish,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] pre_loop_state,
  input  logic               pre_states_valid,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic               iter_end_states_valid,
  input  logic [STATE_W-1:0] quit_loop_state,
  input  logic               quit_states_valid,
  input  logic [STATE_W-1:0] post_loop_state,
  input  logic               post_states_valid,
  input  logic               one_state_loop,
  input  logic               one_state_block,
  output logic               busy,
  output logic               in_loop,
  output logic [CNT_W-1:0]   txn_count,
  output logic [CNT_W-1:0]   txn_last_lat,
  output logic [CNT_W-1:0]   loop_exec_count,
  output logic [CNT_W-1:0]   loop_last_trip,
  output logic [CNT_W-1:0]   loop_last_cycles,
  output logic               frozen
);

  txn_state_e         txn_q, txn_d;
  logic               txn_start, txn_done;
  logic               enable;
  logic [CNT_W-1:0]   lat_q;
  logic [STATE_W-1:0] prev_state;

  // ap_ready is observed but plays no part in counting.
  logic unused_ok;
  assign unused_ok = &{1'b0, ap_ready};

  // The finish cycle itself already suppresses updates, so an in-flight
  // transaction or loop is never recorded once finish is seen.
  assign enable = !(frozen || finish);

  always_comb begin
    txn_d     = txn_q;
    txn_start = 1'b0;
    txn_done  = 1'b0;
    if (enable) begin
      case (txn_q)
        TXN_IDLE: if (ap_start) begin
          txn_start = 1'b1;
          // Start and accepted done together: a complete one-cycle transaction.
          if (ap_done && ap_continue) txn_done = 1'b1;
          else                        txn_d    = TXN_BUSY;
        end
        TXN_BUSY: if (ap_done && ap_continue) begin
          txn_done = 1'b1;
          txn_d    = TXN_IDLE;
        end
        default: txn_d = TXN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txn_q      <= TXN_IDLE;
      frozen     <= 1'b0;
      prev_state <= '0;
    end else begin
      txn_q  <= txn_d;
      frozen <= frozen | finish;
      if (enable) prev_state <= cur_state;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_q        <= '0;
      txn_count    <= '0;
      txn_last_lat <= '0;
    end else if (txn_start && txn_done) begin
      txn_last_lat <= CNT_W'(1);
      txn_count    <= CNT_W'(sat_inc(MAX_CNT_W'(txn_count), CNT_W));
    end else if (txn_start) begin
      lat_q <= CNT_W'(1);
    end else if (txn_done) begin
      // Latency includes the done cycle itself.
      txn_last_lat <= CNT_W'(sat_inc(MAX_CNT_W'(lat_q), CNT_W));
      txn_count    <= CNT_W'(sat_inc(MAX_CNT_W'(txn_count), CNT_W));
    end else if (enable && (txn_q == TXN_BUSY)) begin
      lat_q <= CNT_W'(sat_inc(MAX_CNT_W'(lat_q), CNT_W));
    end
  end

  assign busy = (txn_q == TXN_BUSY);

  seq_loop_tracker #(
    .STATE_W (STATE_W),
    .CNT_W   (CNT_W)
  ) u_loop (
    .clock                 (clock),
    .reset                 (reset),
    .enable                (enable),
    .cur_state             (cur_state),
    .prev_state            (prev_state),
    .pre_loop_state        (pre_loop_state),
    .pre_states_valid      (pre_states_valid),
    .iter_start_state      (iter_start_state),
    .iter_end_state        (iter_end_state),
    .iter_end_states_valid (iter_end_states_valid),
    .quit_loop_state       (quit_loop_state),
    .quit_states_valid     (quit_states_valid),
    .post_loop_state       (post_loop_state),
    .post_states_valid     (post_states_valid),
    .one_state_loop        (one_state_loop),
    .one_state_block       (one_state_block),
    .in_loop               (in_loop),
    .loop_exec_count       (loop_exec_count),
    .loop_last_trip        (loop_last_trip),
    .loop_last_cycles      (loop_last_cycles)
  );

endmodule

// File: tb/tb_seq_loop_status_monitor.sv
// Bench for seq_loop_status_monitor: a 32-bit counter instance and a 4-bit
// counter instance share all inputs. Table-driven transaction vectors,
// hand-written loop sequences, and randomized transactions/loops checked
// against a cycle-counting reference model.
module tb_seq_loop_status_monitor;

  localparam int SW = 9;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1, finish = 1'b0;
  logic [SW-1:0] cur_state = '0;
  logic [SW-1:0] pre_loop_state = '0, iter_start_state = '0, iter_end_state = '0;
  logic [SW-1:0] quit_loop_state = '0, post_loop_state = '0;
  logic pre_states_valid = 1'b0, iter_end_states_valid = 1'b0;
  logic quit_states_valid = 1'b0, post_states_valid = 1'b0;
  logic one_state_loop = 1'b0, one_state_block = 1'b0;

  logic        busy, in_loop, frozen;
  logic [31:0] txn_count, txn_last_lat, loop_exec_count, loop_last_trip, loop_last_cycles;
  logic        busy_4, in_loop_4, frozen_4;
  logic [3:0]  txn_count_4, txn_last_lat_4, loop_exec_count_4, loop_last_trip_4, loop_last_cycles_4;

  int tests = 0;
  int failed = 0;

  always #5 clock = ~clock;

  seq_loop_status_monitor #(.STATE_W(SW), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .cur_state(cur_state),
    .pre_loop_state(pre_loop_state), .pre_states_valid(pre_states_valid),
    .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .iter_end_states_valid(iter_end_states_valid), .quit_loop_state(quit_loop_state),
    .quit_states_valid(quit_states_valid), .post_loop_state(post_loop_state),
    .post_states_valid(post_states_valid), .one_state_loop(one_state_loop),
    .one_state_block(one_state_block), .busy(busy), .in_loop(in_loop),
    .txn_count(txn_count), .txn_last_lat(txn_last_lat), .loop_exec_count(loop_exec_count),
    .loop_last_trip(loop_last_trip), .loop_last_cycles(loop_last_cycles), .frozen(frozen)
  );

  seq_loop_status_monitor #(.STATE_W(SW), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .cur_state(cur_state),
    .pre_loop_state(pre_loop_state), .pre_states_valid(pre_states_valid),
    .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .iter_end_states_valid(iter_end_states_valid), .quit_loop_state(quit_loop_state),
    .quit_states_valid(quit_states_valid), .post_loop_state(post_loop_state),
    .post_states_valid(post_states_valid), .one_state_loop(one_state_loop),
    .one_state_block(one_state_block), .busy(busy_4), .in_loop(in_loop_4),
    .txn_count(txn_count_4), .txn_last_lat(txn_last_lat_4), .loop_exec_count(loop_exec_count_4),
    .loop_last_trip(loop_last_trip_4), .loop_last_cycles(loop_last_cycles_4), .frozen(frozen_4)
  );

  typedef struct {
    logic start;
    logic done;
    logic cont;
    logic exp_busy;
    int   exp_count;
    int   exp_lat;
  } txn_vec_t;

  txn_vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs set before tick() take effect at the next rising edge; outputs are read 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_state(input logic [SW-1:0] s);
    cur_state = s;
    tick();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    cur_state = '0;
    ap_start = 1'b0; ap_done = 1'b0; ap_continue = 1'b1; finish = 1'b0;
    tick();
  endtask

  task automatic cfg_multi(input logic quit_valid);
    pre_loop_state = 9'h001; iter_start_state = 9'h002; iter_end_state = 9'h080;
    quit_loop_state = 9'h080; post_loop_state = 9'h100;
    pre_states_valid = 1'b1; iter_end_states_valid = 1'b1;
    quit_states_valid = quit_valid; post_states_valid = 1'b1;
    one_state_loop = 1'b0; one_state_block = 1'b0;
  endtask

  // pre state, then `iters` passes through states 002..080, then post state.
  task automatic run_multi(input int iters, output logic mid_in_loop);
    drive_state(9'h001);
    mid_in_loop = 1'b0;
    for (int it = 0; it < iters; it++)
      for (int b = 1; b <= 7; b++) begin
        drive_state(SW'(1 << b));
        if (it == 0 && b == 1) mid_in_loop = in_loop;
      end
    drive_state(9'h100);
  endtask

  // Single-state body held for `cycles` cycles, then the post state.
  task automatic run_single(input int cycles, input logic with_pre);
    pre_loop_state = 9'h001; iter_start_state = 9'h002; iter_end_state = 9'h002;
    quit_loop_state = 9'h002; post_loop_state = 9'h100;
    pre_states_valid = with_pre; iter_end_states_valid = 1'b0;
    quit_states_valid = 1'b1; post_states_valid = 1'b1;
    one_state_loop = 1'b1; one_state_block = !with_pre;
    if (with_pre) drive_state(9'h001);
    for (int i = 0; i < cycles; i++) drive_state(9'h002);
    drive_state(9'h100);
    drive_state(9'h000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mid;
    int   exp_exec;
    int   lat, gap, n;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 6};   // done at cycle 5 -> latency 6
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 6};   // done while idle is ignored
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 1};   // start+done together
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 1};   // done without continue held off
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 3};

    // Reset state
    reset = 1'b1;
    tick();
    check("rst_busy", busy, 0);             check("rst_in_loop", in_loop, 0);
    check("rst_frozen", frozen, 0);         check("rst_txn_count", txn_count, 0);
    check("rst_txn_lat", txn_last_lat, 0);  check("rst_exec", loop_exec_count, 0);
    check("rst_trip", loop_last_trip, 0);   check("rst_cycles", loop_last_cycles, 0);
    check("rst4_flags", {busy_4, in_loop_4, frozen_4}, 0);
    check("rst4_cnts", {txn_count_4, txn_last_lat_4, loop_exec_count_4,
                        loop_last_trip_4, loop_last_cycles_4}, 0);
    reset = 1'b0;
    tick();

    // Transaction vectors
    for (int i = 0; i < 11; i++) begin
      ap_start = vecs[i].start; ap_done = vecs[i].done; ap_continue = vecs[i].cont;
      tick();
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_count", i), txn_count, vecs[i].exp_count);
      check($sformatf("vec%0d_lat", i), txn_last_lat, vecs[i].exp_lat);
    end
    ap_start = 1'b0; ap_done = 1'b0; ap_continue = 1'b1;
    tick();

    // Three-iteration loop
    cfg_multi(1'b1);
    run_multi(3, mid);
    check("s2_mid_in_loop", mid, 1);
    check("s2_in_loop", in_loop, 0);
    check("s2_trip", loop_last_trip, 3);
    check("s2_cycles", loop_last_cycles, 21);
    check("s2_exec", loop_exec_count, 1);
    check("s2_cycles_sat4", loop_last_cycles_4, 15);
    drive_state(9'h000);

    // Single-state loop, pre-qualified
    run_single(4, 1'b1);
    check("s3_trip", loop_last_trip, 4);
    check("s3_cycles", loop_last_cycles, 4);
    check("s3_exec", loop_exec_count, 2);
    // Single-state loop with unqualified entry, 20 cycles: 4-bit counters saturate
    run_single(20, 1'b0);
    check("s6_trip", loop_last_trip, 20);
    check("s6_cycles", loop_last_cycles, 20);
    check("s6_trip_sat4", loop_last_trip_4, 15);
    check("s6_cycles_sat4", loop_last_cycles_4, 15);
    check("s6_exec4", loop_exec_count_4, 3);

    // Randomized transactions: latency = cycles from start through accepted done
    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 3);
      lat = $urandom_range(1, 8);
      for (int g = 0; g < gap; g++) begin
        ap_start = 1'b0; ap_done = 1'($urandom_range(0, 1)); ap_ready = 1'($urandom_range(0, 1));
        tick();
      end
      ap_start = 1'b1; ap_ready = 1'($urandom_range(0, 1));
      ap_done = (lat == 1); ap_continue = 1'b1;
      tick();
      ap_start = 1'b0;
      for (int c = 2; c < lat; c++) begin
        // A done without continue is not an accepted completion.
        ap_done = 1'($urandom_range(0, 1)); ap_continue = 1'b0; ap_ready = 1'($urandom_range(0, 1));
        tick();
      end
      if (lat > 1) begin
        ap_done = 1'b1; ap_continue = 1'b1;
        tick();
      end
      ap_done = 1'b0; ap_continue = 1'b1;
      check($sformatf("rnd_txn%0d_lat", t), txn_last_lat, lat);
      check($sformatf("rnd_txn%0d_count", t), txn_count, 4 + t);
      check($sformatf("rnd_txn%0d_busy", t), busy, 0);
    end

    // Randomized loop executions
    cfg_multi(1'b1);
    exp_exec = 3;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 5);
      run_multi(n, mid);
      drive_state(9'(1 << $urandom_range(1, 6)));   // stray body state while idle: no entry
      exp_exec++;
      check($sformatf("rnd_loop%0d_trip", k), loop_last_trip, n);
      check($sformatf("rnd_loop%0d_cycles", k), loop_last_cycles, 7 * n);
      check($sformatf("rnd_loop%0d_exec", k), loop_exec_count, exp_exec);
      check($sformatf("rnd_loop%0d_cyc4", k), loop_last_cycles_4, (7 * n > 15) ? 15 : 7 * n);
      check($sformatf("rnd_loop%0d_in", k), in_loop, 0);
    end

    // Quit qualifier disabled: the loop never exits
    apply_reset();
    cfg_multi(1'b0);
    run_multi(3, mid);
    check("s4_in_loop", in_loop, 1);
    check("s4_exec", loop_exec_count, 0);

    // Asynchronous reset while in the loop
    reset = 1'b1;
    #1;
    check("s6_async_in_loop", in_loop, 0);
    check("s6_async_busy", busy, 0);
    check("s6_async_trip", loop_last_trip, 0);
    reset = 1'b0;
    cur_state = '0;
    tick();
    cfg_multi(1'b1);
    run_multi(3, mid);
    check("s6_rerun_trip", loop_last_trip, 3);
    check("s6_rerun_cycles", loop_last_cycles, 21);
    check("s6_rerun_exec", loop_exec_count, 1);
    drive_state(9'h000);

    // finish mid-transaction
    apply_reset();
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check("s5_frozen", frozen, 1);
    check("s5_count", txn_count, 0);
    ap_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ap_done = 1'b0;
    check("s5_count_after_done", txn_count, 0);
    check("s5_lat_after_done", txn_last_lat, 0);
    check("s5_busy_held", busy, 1);
    check("s5_frozen_sticky", frozen, 1);
    run_multi(2, mid);
    check("s5_loop_in", in_loop, 0);
    check("s5_loop_exec", loop_exec_count, 0);
    apply_reset();
    check("s5_unfrozen", frozen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
